hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Central hazard unit driving the ID/EX register's bubble input and the PC / IF-ID stall and flush controls.
//  Detects load-use hazards, taken branches and jumps resolved in EX, and MDU ops in ID while a multi-cycle mult runs.
//  Sits beside the decode stage; all outputs are sampled at the next posedge by PC, IF/ID and ID/EX.
// PARAMETERS
//  MULT_CYCLES  4   EX-occupancy of a mult, in cycles (>=2); MDU results are valid after it
//  PERF_W       16  width of the saturating stall-cycle counter
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       synchronous active-low reset
//  id_rs         in   5       rs of instruction in ID
//  id_rt         in   5       rt of instruction in ID
//  id_uses_rt    in   1       ID instruction reads rt (R-type, beq/bne, sw/sb)
//  id_mdu_op     in   1       ID instruction is mult/mflo/mfhi/mtlo/mthi
//  ex_MemRead    in   1       EX instruction is a load (lw/lb)
//  ex_rt         in   5       destination of the EX load
//  ex_mult       in   1       EX instruction is mult (first EX cycle)
//  ex_redirect   in   1       taken beq/bne/bgez/bgtz/blez/bltz, or jump/jal/jalr in EX
//  bubble        out  2       to ID/EX: 00 pass, 01 load-use, 10 redirect flush, 11 MDU stall
//  pc_stall      out  1       hold PC
//  ifid_stall    out  1       hold IF/ID
//  ifid_flush    out  1       zero IF/ID (becomes nop)
//  mdu_busy      out  1       mult in flight
//  perf_stalls   out  PERF_W  cycles with bubble!=00, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, mdu_cnt=0, perf_stalls=0.
//   During reset, all control outputs are forced to 0 combinationally.
//  Control outputs are combinational from the current inputs plus registered state, with zero latency.
//  load_use = ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  mdu_hold = mdu_busy & id_mdu_op.
//  Priority, one case per cycle:
//   1 ex_redirect: bubble=10, ifid_flush=1, pc_stall=0, ifid_stall=0
//   2 mdu_hold:    bubble=11, pc_stall=1, ifid_stall=1
//   3 load_use:    bubble=01, pc_stall=1, ifid_stall=1
//   4 else:        bubble=00, all others 0
//  ifid_flush and ifid_stall are never both 1.
//  A load-use hazard lasts exactly 1 cycle; the load then moves to MEM and is forwarded.
//  FSM states: IDLE, MDU_WAIT.
//   IDLE -> MDU_WAIT when ex_mult=1; mdu_cnt loads MULT_CYCLES-1.
//   MDU_WAIT: mdu_cnt decrements each cycle; -> IDLE when the decrement reaches 0.
//   If ex_mult=1 in the same cycle mdu_cnt reaches 0, mdu_cnt reloads MULT_CYCLES-1 and state stays MDU_WAIT.
//   mdu_busy = (state==MDU_WAIT).
//  ex_redirect does not cancel an issued mult; mdu_cnt keeps counting.
//  Reset mid-mult: the FSM returns to IDLE and mdu_busy=0 on the next cycle.
//  perf_stalls increments when bubble!=00 and saturates at all-ones (no wrap).
//  id_rs/id_rt equal to 0 never match a load (r0 is never a hazard).
// TESTING
//  Load-use: ex_MemRead=1, ex_rt=8, id_rs=8 -> bubble=01, pc_stall=ifid_stall=1 for 1 cycle, then 00.
//  r0 load: ex_MemRead=1, ex_rt=0, id_rs=0 -> bubble=00, no stall.
//  MDU stall: ex_mult=1, then mfhi held in ID -> bubble=11 for 3 cycles (MULT_CYCLES=4), then 00;
//   mdu_busy drops after cycle 4.
//  Redirect over load-use: ex_redirect=1 with load_use=1 -> bubble=10, ifid_flush=1, pc_stall=0.
//  Reset mid-mult: rst_n=0 at 2nd busy cycle -> next cycle mdu_busy=0, perf_stalls=0, bubble=00.
//  Saturation: PERF_W=4, 20 stall cycles -> perf_stalls=15 and holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard unit for the decode stage: load-use, EX redirect and MDU-busy detection
// driving the ID/EX bubble code, PC / IF-ID stall and flush, plus a stall-cycle counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              id_mdu_op,
    input  logic              ex_MemRead,
    input  logic [4:0]        ex_rt,
    input  logic              ex_mult,
    input  logic              ex_redirect,
    output logic [1:0]        bubble,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] perf_stalls
);

    localparam int CNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

    typedef enum logic {IDLE, MDU_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             mdu_hold;

    assign mdu_busy = (state_q == MDU_WAIT);
    assign mdu_hold = mdu_busy & id_mdu_op;
    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign load_use = ex_MemRead & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new mult always restarts the count, including the cycle the old one finishes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ex_mult) begin
                    state_d = MDU_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            MDU_WAIT: begin
                if (ex_mult) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bubble     = 2'b00;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        if (rst_n) begin
            if (ex_redirect) begin
                bubble     = 2'b10;
                ifid_flush = 1'b1;
            end else if (mdu_hold) begin
                bubble     = 2'b11;
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
            end else if (load_use) begin
                bubble     = 2'b01;
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stalls <= '0;
        end else if ((bubble != 2'b00) && (perf_stalls != {PERF_W{1'b1}})) begin
            perf_stalls <= perf_stalls + PERF_W'(1);
        end
    end

endmodule
